// File: rtl/parameterized_counter.sv
// Saturating up/down counter with synchronous reset load; one-cycle latency, no handshake.
// Define PARAMETERIZED_COUNTER_WRAP_EN to make both ends wrap around instead of saturate.
module parameterized_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  input  logic [WIDTH-1:0] initial_value,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_next;

  // up and down together cancel out and hold the count
  always_comb begin
    count_next = count;
    if (up && !down) begin
      if (count != MAX_VAL) begin
        count_next = count + ONE;
      end else begin
`ifdef PARAMETERIZED_COUNTER_WRAP_EN
        count_next = MIN_VAL;
`else
        count_next = MAX_VAL;
`endif
      end
    end else if (down && !up) begin
      if (count != MIN_VAL) begin
        count_next = count - ONE;
      end else begin
`ifdef PARAMETERIZED_COUNTER_WRAP_EN
        count_next = MAX_VAL;
`else
        count_next = MIN_VAL;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= initial_value;
    end else begin
      count <= count_next;
    end
  end

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == MIN_VAL);

endmodule

// File: tb/tb_parameterized_counter.sv
// Randomized and directed stimulus against an integer reference model; a monitor scoreboards every edge.
module tb_parameterized_counter;

  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef PARAMETERIZED_COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             up = 1'b0;
  logic             down = 1'b0;
  logic [WIDTH-1:0] initial_value = '0;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;

  int n_chk  = 0;
  int n_pass = 0;
  int mdl    = 0;
  int exp_q[$];

  parameterized_counter #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .up            (up),
    .down          (down),
    .initial_value (initial_value),
    .count         (count),
    .at_max        (at_max),
    .at_min        (at_min)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
  endtask

  // Reference: plain integer step, then clamp or wrap whatever left the legal range
  task automatic step(input bit r, input bit u, input bit d, input logic [WIDTH-1:0] iv);
    int nxt;
    @(negedge clk);
    rst_n = r; up = u; down = d; initial_value = iv;
    if (!r) begin
      nxt = int'(iv);
    end else begin
      nxt = mdl + int'(u) - int'(d);
      if (nxt > MAXV) nxt = WRAP ? 0 : MAXV;
      if (nxt < 0)    nxt = WRAP ? MAXV : 0;
    end
    mdl = nxt;
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_count",  64'(count),  64'(e));
        chk("sb_at_max", 64'(at_max), 64'(e == MAXV));
        chk("sb_at_min", 64'(at_min), 64'(e == 0));
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [WIDTH-1:0] iv;
    int pick;

    // reset load of zero
    step(0, 0, 0, 8'h00);
    chk("reset_count", 64'(count), 64'h00);
    chk("reset_at_min", 64'(at_min), 64'd1);
    step(1, 0, 0, 8'h00);
    chk("idle_count", 64'(count), 64'h00);

    // count up then down
    step(0, 0, 0, 8'h10);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 8'h10);
    chk("up5", 64'(count), 64'h15);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h10);
    chk("down3", 64'(count), 64'h12);

    // upper boundary
    step(0, 0, 0, 8'hFE);
    step(1, 1, 0, 8'hFE);
    chk("to_max", 64'(count), 64'hFF);
    chk("to_max_flag", 64'(at_max), 64'd1);
    step(1, 1, 0, 8'hFE);
    chk("past_max", 64'(count), WRAP ? 64'h00 : 64'hFF);
    step(1, 1, 0, 8'hFE);
    step(1, 1, 0, 8'hFE);
    chk("past_max3", 64'(count), WRAP ? 64'h02 : 64'hFF);

    // lower boundary
    step(0, 0, 0, 8'h00);
    step(1, 0, 1, 8'h00);
    chk("below_min", 64'(count), WRAP ? 64'hFF : 64'h00);
    step(0, 0, 0, 8'h05);
    step(1, 0, 1, 8'h05);
    step(1, 0, 1, 8'h05);
    chk("down2", 64'(count), 64'h03);

    // simultaneous requests, reload priority, ignored initial_value
    step(0, 0, 0, 8'h10);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 8'h10);
    chk("both_hold", 64'(count), 64'h10);
    step(0, 1, 0, 8'hAA);
    chk("reload_prio", 64'(count), 64'hAA);
    step(1, 0, 0, 8'h55);
    step(1, 0, 0, 8'h33);
    chk("iv_ignored", 64'(count), 64'hAA);

    // randomized traffic, seeds biased towards the boundaries
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: iv = 8'h00;
        1: iv = 8'h01;
        2: iv = 8'hFE;
        3: iv = 8'hFF;
        default: iv = WIDTH'($urandom);
      endcase
      step(($urandom_range(0, 19) != 0), $urandom_range(0, 1) != 0,
           $urandom_range(0, 1) != 0, iv);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
